// File: rtl/uart_pkg.sv
// Shared UART register-access types: the command/response packet and the
// command-type codes used by uart_tx, the command executor and rsp_fifo.
package uart_pkg;

  typedef struct packed {
    logic [1:0] cmd_type;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ERROR = 2'b11;

endpackage

// File: rtl/rsp_fifo.sv
// Response FIFO between the command executor and uart_tx; pops on the rising
// edge of uart_tx's read request so a level held for a baud period pops once.
module rsp_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  cmd_packet_t                  wr_data,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         data_read_en,
  output cmd_packet_t                  cmd_rsp,
  output logic                         data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  cmd_packet_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rd_q;
  logic          pop;
  logic          pop_ok;
  logic          push;

  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign data_ready  = (count != '0);

  // rd_q resets high so a request still asserted across reset release is not an edge
  assign pop    = data_read_en & ~rd_q;
  assign pop_ok = pop & data_ready;
  assign push   = wr_en & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_rsp   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_q <= data_read_en;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        cmd_rsp <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en & ~push) begin
        overflow <= 1'b1;
      end
      if (pop & ~data_ready) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count alone define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rsp_fifo.sv
// Self-checking bench for rsp_fifo: a vector table, directed corner-case
// sequences and randomized traffic checked against a queue-based model.
module tb_rsp_fifo;
  import uart_pkg::*;

  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  cmd_packet_t wr_data = '0;
  logic        full;
  logic        almost_full;
  logic        data_read_en = 1'b0;
  cmd_packet_t cmd_rsp;
  logic        data_ready;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the last popped head and sticky flags
  cmd_packet_t mq[$];
  cmd_packet_t m_rsp;
  logic        m_rdq;
  logic        m_ovf;
  logic        m_unf;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       dr;
    logic [7:0] rsp;
    logic       unf;
  } vec_t;

  vec_t tbl[10];

  rsp_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .data_read_en (data_read_en),
    .cmd_rsp      (cmd_rsp),
    .data_ready   (data_ready),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic cmd_packet_t mk(input logic [7:0] d);
    cmd_packet_t p;
    p.cmd_type = d[1:0];
    p.addr     = ~d;
    p.data     = d;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_rsp = '0;
    m_rdq = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic modelEdge(input logic w, input logic r, input cmd_packet_t d);
    logic pop, pok, psh;
    pop = r & ~m_rdq;
    pok = pop && (mq.size() > 0);
    psh = w && ((mq.size() < DEPTH) || pok);
    if (pop && !pok) m_unf = 1'b1;
    if (w && !psh)   m_ovf = 1'b1;
    if (pok) m_rsp = mq.pop_front();
    if (psh) mq.push_back(d);
    m_rdq = r;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"},       32'(count),       32'(mq.size()));
    check({tag, ".full"},        32'(full),        32'(mq.size() == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
    check({tag, ".data_ready"},  32'(data_ready),  32'(mq.size() != 0));
    check({tag, ".cmd_rsp"},     32'(cmd_rsp),     32'(m_rsp));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    check({tag, ".underflow"},   32'(underflow),   32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance past the edge, and compare with the model
  task automatic applyStimulus(input logic w, input logic r, input cmd_packet_t d, input string tag);
    wr_en        = w;
    data_read_en = r;
    wr_data      = d;
    @(posedge clk);
    modelEdge(w, r, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset(input int cycles);
    rst   = 1'b1;
    wr_en = 1'b0;
    modelReset();
    #1;
    check("reset.async_count", 32'(count), 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset");
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 1, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'hB6, 2, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hA5, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hA5, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1, 1'b1, 8'hA5, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hB6, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hB6, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'hC7, 1, 1'b1, 8'hB6, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1, 1'b1, 8'hB6, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hC7, 1'b1};

    modelReset();
    repeat (2) @(posedge clk);
    doReset(2);
    check("reset.cmd_rsp", 32'(cmd_rsp), 32'd0);
    check("reset.flags", 32'({full, almost_full, data_ready, overflow, underflow}), 32'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].wr, tbl[i].rd, mk(tbl[i].d), $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.cnt", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d.dr", i), 32'(data_ready), 32'(tbl[i].dr));
      check($sformatf("tbl%0d.rsp", i), 32'(cmd_rsp.data), 32'(tbl[i].rsp));
      check($sformatf("tbl%0d.unf", i), 32'(underflow), 32'(tbl[i].unf));
    end

    // Push then held read: one pop only
    doReset(1);
    applyStimulus(1'b1, 1'b0, '{2'b01, 8'h10, 8'hA5}, "held.push");
    applyStimulus(1'b0, 1'b1, '0, "held.edge");
    check("held.rsp", 32'(cmd_rsp), 32'h0_10A5 | 32'h1_0000);
    check("held.cnt0", 32'(count), 32'd0);
    for (int i = 0; i < 49; i++) applyStimulus(1'b0, 1'b1, '0, "held.level");
    check("held.unf", 32'(underflow), 32'd0);
    check("held.dr", 32'(data_ready), 32'd0);

    // Fill and overflow
    doReset(1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, mk(8'(i)), "fill.push");
      if (i == 10) check("fill.af_at11", 32'(almost_full), 32'd0);
      if (i == 11) check("fill.af_at12", 32'(almost_full), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, mk(8'h10), "fill.push17");
    check("fill.full", 32'(full), 32'd1);
    check("fill.ovf", 32'(overflow), 32'd1);
    check("fill.cnt", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, '0, "fill.pop");
      check($sformatf("fill.data%0d", i), 32'(cmd_rsp.data), 32'(i));
      applyStimulus(1'b0, 1'b0, '0, "fill.idle");
    end

    // Full with simultaneous push and pop
    doReset(1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, mk(8'(i)), "simul.fill");
    applyStimulus(1'b1, 1'b1, mk(8'hEE), "simul.both");
    check("simul.cnt", 32'(count), 32'd16);
    check("simul.ovf", 32'(overflow), 32'd0);
    check("simul.rsp", 32'(cmd_rsp.data), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, '0, "simul.idle");
      applyStimulus(1'b0, 1'b1, '0, "simul.pop");
      check($sformatf("simul.data%0d", i), 32'(cmd_rsp.data), (i == 15) ? 32'hEE : 32'(i + 1));
    end

    // Pop edge while empty
    applyStimulus(1'b0, 1'b0, '0, "empty.idle");
    applyStimulus(1'b0, 1'b1, '0, "empty.pop");
    check("empty.unf", 32'(underflow), 32'd1);
    check("empty.rsp", 32'(cmd_rsp.data), 32'hEE);
    check("empty.cnt", 32'(count), 32'd0);

    // Wrap-around
    doReset(1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, mk(8'(i + 8'h30)), "wrap.push");
      applyStimulus(1'b0, 1'b1, '0, "wrap.pop");
      check($sformatf("wrap.data%0d", i), 32'(cmd_rsp.data), 32'(i + 8'h30));
      check("wrap.cnt_le2", 32'(count <= 5'd2), 32'd1);
    end

    // Reset mid-operation with the read request held high
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, mk(8'(i + 8'h50)), "midrst.push");
    applyStimulus(1'b0, 1'b1, '0, "midrst.pop");
    doReset(3);
    check("midrst.cnt", 32'(count), 32'd0);
    check("midrst.rsp", 32'(cmd_rsp), 32'd0);
    check("midrst.flags", 32'({full, almost_full, data_ready, overflow, underflow}), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0, "midrst.hold");
    check("midrst.nopop_unf", 32'(underflow), 32'd0);
    applyStimulus(1'b1, 1'b0, mk(8'h77), "midrst.push2");
    applyStimulus(1'b0, 1'b1, '0, "midrst.pop2");
    check("midrst.rt_data", 32'(cmd_rsp.data), 32'h77);
    check("midrst.rt_cnt", 32'(count), 32'd0);

    // Randomized traffic against the model
    doReset(1);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)),
                    mk(8'($urandom)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsp_fifo.md
# rsp_fifo

Response FIFO between the register-access command executor and `uart_tx`. It buffers `cmd_packet_t` responses written at system-clock rate and hands them one at a time to `uart_tx`, which drains them at baud rate. `uart_tx` holds its read request high for a whole baud period, so the block pops on the rising edge of that request rather than its level.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AF_LEVEL`, 12: `almost_full` threshold, 1..DEPTH.

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_en` input 1: push request from the command executor.
- `wr_data` input `cmd_packet_t`: response to push.
- `full` output 1: `count == DEPTH`.
- `almost_full` output 1: `count >= AF_LEVEL`.
- `data_read_en` input 1: pop request from `uart_tx`; level may persist for many cycles.
- `cmd_rsp` output `cmd_packet_t`: registered head data; held stable between pops.
- `data_ready` output 1: `count != 0`.
- `count` output `$clog2(DEPTH+1)`: current occupancy.
- `overflow` output 1: sticky; a push was dropped.
- `underflow` output 1: sticky; a pop edge arrived while empty.

## Operation
- **Pop edge.**
  - `rd_q` is `data_read_en` delayed one cycle.
  - `pop = data_read_en & ~rd_q`.
  - `rd_q` resets to 1, so a `data_read_en` left high across reset release does not pop.
- **Push.**
  - `push = wr_en & (~full | pop_ok)`, where `pop_ok = pop & data_ready`.
  - When full, a write is accepted only if a valid pop occurs in the same cycle.
  - A rejected write sets `overflow`; storage and pointers are unchanged.
- **Pop.**
  - When `pop & data_ready`: `cmd_rsp <= mem[rd_ptr]`, `rd_ptr` increments.
  - When `pop & ~data_ready`: `underflow` is set; `cmd_rsp`, pointers and `count` are unchanged.
- **Pointers.** `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **Count.**
  - `count` changes by +1 on push only, −1 on pop only, 0 when both happen in the same cycle.
  - `count` never exceeds DEPTH and never goes below 0.
- **Simultaneous push and pop when empty.** The pop is an underflow and the push is stored; this is not a bypass.
- **Sticky flags.** `overflow` and `underflow` clear only on reset.
- **Ordering.** Strict FIFO order; no reordering or merging.

## Timing
- **Reset values.**
  - 0: `count`, both pointers, `cmd_rsp` (all fields), `full`, `almost_full`, `data_ready`, `overflow`, `underflow`.
  - 1: `rd_q`.
- **Reset mid-operation.** All stored entries are discarded immediately; the first push after reset release is accepted.
- **Status flags.** `full`, `almost_full` and `data_ready` are decoded from `count` and are valid the cycle after the push/pop edge that changed it.
- **Write latency.** Data pushed at edge N is poppable at edge N+1 (`data_ready` high after edge N).
- **Read latency.** For a pop edge at clock edge N (`data_read_en` first seen high), `cmd_rsp` holds the new head after edge N. `uart_tx` samples it at least one baud tick later.
- **Second pop.** A second pop requires `data_read_en` to go low for at least one cycle and then high again.
- **Throughput.** One push per cycle; one pop per two cycles at most.

## Structure
- `cmd_packet_t` (`cmd_type[1:0]`, `addr[7:0]`, `data[7:0]`) and any command-type constants live in the shared `uart_pkg`, which is imported by `uart_tx`, the command executor and this block.
- No sub-module: storage is an inferred `DEPTH`-entry array of `cmd_packet_t`.
- The edge detector and pointer logic are inline.

## Test plan
- **Push then held read.** Push one entry {cmd_type=2'b01, addr=8'h10, data=8'hA5}, then hold `data_read_en` high for 50 cycles → exactly one pop; `cmd_rsp` = that entry one cycle after the rising edge; `count` goes 1→0; `data_ready` drops; no `underflow`.
- **Fill and overflow.** Push 16 entries with `data` 0x00..0x0F, then push a 17th → `full=1` and `almost_full=1` (from count 12); 17th dropped; `overflow=1`; 16 pop edges return data 0x00..0x0F in order.
- **Full with simultaneous push and pop.** With the FIFO full, push 8'hEE in the same cycle as a pop edge → write accepted; `count` stays 16; `overflow` stays 0; 8'hEE emerges last.
- **Pop while empty.** Generate a pop edge while empty → `underflow=1`; `cmd_rsp` unchanged from its prior value; `count=0`.
- **Wrap-around.** Run 40 interleaved push/pop pairs with incrementing data → data out matches data in across pointer wrap; `count` never exceeds 2.
- **Reset mid-operation.** With 5 entries stored and `data_read_en` high, assert `rst` for 3 cycles, then release with `data_read_en` still high → all outputs 0; no pop occurs until `data_read_en` toggles low then high; a subsequent push/pop round trip works.
